// File: rtl/botoes_pkg.sv
// Shared definitions for the button event controller: per-button FSM states
// and the bit layout of one queued event.
package botoes_pkg;

  typedef enum logic [1:0] {
    OCIOSO      = 2'd0,
    PRESSIONADO = 2'd1,
    LONGO       = 2'd2
  } estado_t;

  // Event word: {index, longo}; the long flag sits in bit 0.
  localparam int EV_LONGO_BIT = 0;
  localparam int EV_IDX_LSB   = 1;

  function automatic int ev_largura(input int n_botoes);
    return $clog2(n_botoes) + 1;
  endfunction

endpackage

// File: rtl/fila_eventos.sv
// Synchronous show-ahead FIFO: dout always presents the head entry while not empty.
module fila_eventos #(
  parameter int W     = 3,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     vazio,
  output logic                     cheio,
  output logic [$clog2(DEPTH):0]   nivel
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] NIVEL_MAX = (AW + 1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0]   r_nivel;
  logic          w_do_push, w_do_pop;

  assign vazio     = (r_nivel == '0);
  assign cheio     = (r_nivel == NIVEL_MAX);
  assign w_do_pop  = pop & ~vazio;
  assign w_do_push = push & (~cheio | w_do_pop);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_nivel <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
      if (w_do_push && !w_do_pop)      r_nivel <= r_nivel + 1'b1;
      else if (!w_do_push && w_do_pop) r_nivel <= r_nivel - 1'b1;
    end
  end

  // NOTE: storage is left unreset; occupancy and pointers alone define what
  // is valid, and dout is forced to zero while empty.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr] <= din;
  end

  assign dout  = vazio ? '0 : r_mem[r_rd];
  assign nivel = r_nivel;

endmodule

// File: rtl/arbitro_botoes.sv
// Button event controller: classifies debounced presses as short or long,
// arbitrates them round-robin and queues them behind a valid/ready FIFO.
module arbitro_botoes
  import botoes_pkg::*;
#(
  parameter int N_BOTOES    = 4,
  parameter int LONG_CYCLES = 50_000_000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_BOTOES-1:0]           b_pulso,
  input  logic [N_BOTOES-1:0]           b_hold,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [$clog2(N_BOTOES)-1:0]   ev_botao,
  output logic                          ev_longo,
  output logic [$clog2(FIFO_DEPTH):0]   nivel,
  output logic                          overflow
);
  localparam int IW = $clog2(N_BOTOES);
  localparam int EW = ev_largura(N_BOTOES);
  localparam int CW = $clog2(LONG_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LONGO = CW'(LONG_CYCLES - 1);

  logic [N_BOTOES-1:0] w_pend_v, w_pend_l, w_grant, w_drop;
  logic [IW-1:0]       r_rr, w_idx;
  logic                w_sel_longo, w_tem_grant, w_aceita, w_pop;
  logic                w_vazio, w_cheio, r_overflow;
  logic [EW-1:0]       w_din, w_dout;
  int                  w_j;

  for (genvar gi = 0; gi < N_BOTOES; gi++) begin : g_botao
    estado_t       r_estado, w_estado_prox;
    logic [CW-1:0] r_cnt, w_cnt_prox, w_cnt_inc;
    logic          w_posta, w_longo, r_pend_v, r_pend_l;

    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

    // NOTE: every output of a combinational process gets a default first, so
    // no path through the case can infer a latch.
    always_comb begin
      w_estado_prox = r_estado;
      w_cnt_prox    = r_cnt;
      w_posta       = 1'b0;
      w_longo       = 1'b0;
      unique case (r_estado)
        OCIOSO: begin
          if (b_pulso[gi]) begin
            w_estado_prox = PRESSIONADO;
            w_cnt_prox    = '0;
          end
        end
        PRESSIONADO: begin
          if (!b_hold[gi]) begin
            w_posta       = 1'b1;
            w_estado_prox = OCIOSO;
          end else begin
            w_cnt_prox = w_cnt_inc;
            if (w_cnt_inc >= CNT_LONGO) begin
              w_posta       = 1'b1;
              w_longo       = 1'b1;
              w_estado_prox = LONGO;
            end
          end
        end
        LONGO: begin
          if (!b_hold[gi]) w_estado_prox = OCIOSO;
        end
        default: w_estado_prox = OCIOSO;
      endcase
    end

    // A grant in the same cycle frees the pending slot for a new post.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_estado <= OCIOSO;
        r_cnt    <= '0;
        r_pend_v <= 1'b0;
        r_pend_l <= 1'b0;
      end else begin
        r_estado <= w_estado_prox;
        r_cnt    <= w_cnt_prox;
        if (w_posta && (!r_pend_v || w_grant[gi])) begin
          r_pend_v <= 1'b1;
          r_pend_l <= w_longo;
        end else if (w_grant[gi]) begin
          r_pend_v <= 1'b0;
        end
      end
    end

    assign w_pend_v[gi] = r_pend_v;
    assign w_pend_l[gi] = r_pend_l;
    assign w_drop[gi]   = w_posta & r_pend_v & ~w_grant[gi];
  end

  assign w_pop    = ev_valid & ev_ready;
  assign w_aceita = ~w_cheio | w_pop;

  always_comb begin
    w_grant     = '0;
    w_idx       = '0;
    w_sel_longo = 1'b0;
    w_tem_grant = 1'b0;
    w_j         = 0;
    if (w_aceita) begin
      for (int k = 0; k < N_BOTOES; k++) begin
        w_j = int'(r_rr) + k;
        if (w_j >= N_BOTOES) w_j = w_j - N_BOTOES;
        if (!w_tem_grant && w_pend_v[w_j]) begin
          w_tem_grant   = 1'b1;
          w_grant[w_j]  = 1'b1;
          w_idx         = IW'(w_j);
          w_sel_longo   = w_pend_l[w_j];
        end
      end
    end
  end

  always_comb begin
    w_din                       = '0;
    w_din[EV_LONGO_BIT]         = w_sel_longo;
    w_din[EV_IDX_LSB +: IW]     = w_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr       <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_tem_grant) r_rr <= (w_idx == IW'(N_BOTOES - 1)) ? '0 : w_idx + 1'b1;
      if (|w_drop)     r_overflow <= 1'b1;
    end
  end

  fila_eventos #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fila (
    .clk   (clk),
    .rst   (rst),
    .push  (w_tem_grant),
    .din   (w_din),
    .pop   (w_pop),
    .dout  (w_dout),
    .vazio (w_vazio),
    .cheio (w_cheio),
    .nivel (nivel)
  );

  assign ev_valid = ~w_vazio;
  assign ev_botao = w_dout[EV_IDX_LSB +: IW];
  assign ev_longo = w_dout[EV_LONGO_BIT];
  assign overflow = r_overflow;

endmodule

// File: doc/arbitro_botoes.md
# arbitro_botoes

Event controller placed between the per-button debouncers and the pet game FSM. It takes each debouncer's one-cycle press pulse and its held level, and classifies every press as short or long. Events from all buttons go through a round-robin arbiter into a small FIFO. The FIFO has a valid/ready handshake, so the game FSM consumes exactly one button event at a time and never loses simultaneous presses.

## Interface
- N_BOTOES, 4: number of debounced buttons.
- LONG_CYCLES, 50_000_000: hold duration in clk cycles (counted from the press pulse) at which a press becomes long. Must be ≥2.
- FIFO_DEPTH, 4: event FIFO entries. Must be a power of 2.
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- b_pulso  in  N_BOTOES  one-cycle press pulse per button, from the debouncer.
- b_hold  in  N_BOTOES  per-button pressed level, from the debouncer.
- ev_valid  out  1  FIFO head holds an event.
- ev_ready  in  1  consumer accepts the head this cycle.
- ev_botao  out  $clog2(N_BOTOES)  button index of the head event.
- ev_longo  out  1  head event is a long press (0 = short).
- nivel  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky flag: an event was dropped. Cleared only by rst.

## Operation
- Each button has its own FSM with states OCIOSO, PRESSIONADO and LONGO, plus a hold counter and a one-entry pending register (valid + longo).
- OCIOSO:
  - b_pulso[i]=1 moves to PRESSIONADO and clears the counter.
  - b_hold without a prior pulse is ignored.
- PRESSIONADO:
  - The counter increments every cycle that b_hold[i]=1. Counter width is $clog2(LONG_CYCLES+1) and it saturates.
  - b_hold[i]=0 before the count reaches LONG_CYCLES-1 posts a short event and returns to OCIOSO.
  - Count reaching LONG_CYCLES-1 with b_hold[i] still 1 posts a long event and moves to LONGO.
- LONGO: stays until b_hold[i]=0, then returns to OCIOSO. Release after a long press posts no event.
- b_pulso[i] is ignored in any state other than OCIOSO.
- Posting an event:
  - The event sets the button's pending register.
  - If that register is already valid, the new event is dropped and overflow is set. The FSM transition still happens.
- Arbiter:
  - Each cycle, if the FIFO can accept, it grants one valid pending register, searching round-robin from pointer rr.
  - Granted: {index, longo} is pushed, that pending register is cleared, and rr becomes index+1 mod N_BOTOES.
  - No grant: rr is unchanged.
- FIFO:
  - Show-ahead: ev_botao and ev_longo reflect the head whenever ev_valid=1. They are don't-care otherwise.
  - Pop happens when ev_valid & ev_ready.
  - Can accept when nivel<FIFO_DEPTH, or when full with a pop in the same cycle.
  - Simultaneous push and pop leaves nivel unchanged.
- Pending registers and the FIFO together give lossless buffering. The only loss path is the same button posting twice while its pending register is still blocked by a full FIFO.

## Timing
- Reset values:
  - Outputs: ev_valid=0, ev_botao=0, ev_longo=0, nivel=0, overflow=0.
  - Internal: all FSMs OCIOSO, counters 0, pending cleared, rr=0, FIFO pointers 0.
- Reset takes priority over every other event in the same cycle. Reset mid-press discards that press, including pending and queued events.
- Latency:
  - The post condition is sampled at edge t and the pending register is valid after edge t.
  - The arbiter push happens at edge t+1.
  - With an empty FIFO, ev_valid=1 in the cycle after edge t+1: two clocks from the sampling edge.
- A long event needs b_hold high for LONG_CYCLES-1 cycles after the pulse cycle.
- The arbiter accepts at most one push per cycle. K simultaneous posts reach the FIFO over K consecutive cycles in rr order.
- ev_ready may be held high permanently, giving one pop per cycle.
- ev_valid, ev_botao, ev_longo and nivel are registered; there is no combinational path from the inputs to them.

## Structure
- Shared package/include botoes_pkg holds:
  - FSM state encodings (OCIOSO=2'd0, PRESSIONADO=2'd1, LONGO=2'd2).
  - Event field layout (index width, longo bit position).
- Sub-module fila_eventos: synchronous show-ahead FIFO with ports clk, rst, push, din, pop, dout, vazio, cheio, nivel.
- Per-button FSMs use a generate loop inside arbitro_botoes.

## Test plan
Bench parameters: LONG_CYCLES=20, N_BOTOES=4, FIFO_DEPTH=4.
- Short press, ev_ready=1: pulse on b0, b_hold high for 5 cycles -> exactly one event {botao=0, longo=0}, ev_valid high 2 cycles after release is sampled, nivel returns to 0.
- Long press: b2 pulse, hold 40 cycles -> one event {2, 1} posted when the count reaches 19. No event on release.
- Simultaneous posts: b0, b1 and b3 release in the same cycle with rr=0 and ev_ready=0 -> FIFO order 0, 1, 3, nivel=3, next rr=0.
- Full FIFO and overflow, ev_ready=0:
  - Post 4 events -> nivel=4.
  - A fifth event on b1 stays pending.
  - A second b1 event -> dropped, overflow=1.
  - Raise ev_ready -> 5 events drain in order, overflow stays 1.
- Full FIFO with push and pop together: nivel=4, ev_ready=1 and a pending event -> nivel stays 4 and the new event appears last.
- Reset mid-operation: rst for 1 cycle while b1 is in PRESSIONADO with 2 events queued -> all outputs at reset values. b_hold still high after reset -> no event until a new pulse arrives.
